// File: rtl/ldpc_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_pkg
// Shared constants and types for the GF(257) 4x24 LDPC decoder CPU-side
// logic.
//   NUM_COL    : number of column memories (banks) read in parallel
//   DATA_WIDTH : symbol width; GF(257) symbols need 9 bits
//   COL_W      : width of a column index
//   rd_state_t : state encoding of the cpu_rd_gen readback FSM
// ---------------------------------------------------------------------------
package ldpc_pkg;

    localparam int NUM_COL    = 24;
    localparam int DATA_WIDTH = 9;
    localparam int COL_W      = $clog2(NUM_COL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_SEND,
        ST_DONE
    } rd_state_t;

endpackage

// File: rtl/rd_row_serializer.sv
// ---------------------------------------------------------------------------
// rd_row_serializer
// Holds one captured row (one symbol per column bank). It presents the row
// to the CPU one column at a time over a valid/ready stream, column 0 first.
//   clk, rst_n  : clock and asynchronous active-low reset
//   i_capture   : load i_row_data into the row buffer and restart at col 0
//   i_send      : the row is being streamed (drives o_valid)
//   i_ready     : CPU accepts the current beat
//   i_row_data  : bank i symbol at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_valid     : beat valid
//   o_data      : symbol of the current column
//   o_col       : current column index
//   o_row_end   : handshake on the final column of the row
// ---------------------------------------------------------------------------
module rd_row_serializer
    import ldpc_pkg::*;
#(
    parameter int NUM_COL    = ldpc_pkg::NUM_COL,
    parameter int DATA_WIDTH = ldpc_pkg::DATA_WIDTH,
    parameter int COL_W      = $clog2(NUM_COL)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_capture,
    input  logic                          i_send,
    input  logic                          i_ready,
    input  logic [NUM_COL*DATA_WIDTH-1:0] i_row_data,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [COL_W-1:0]              o_col,
    output logic                          o_row_end
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

    logic [DATA_WIDTH-1:0] r_row_buf [NUM_COL];
    logic [COL_W-1:0]      r_col;
    logic                  w_handshake;

    assign w_handshake = i_send & i_ready;
    assign o_valid     = i_send;
    assign o_data      = r_row_buf[r_col];
    assign o_col       = r_col;
    assign o_row_end   = w_handshake && (r_col == LAST_COL);

    // The column counter parks on the last column after the final handshake;
    // the next capture rewinds it, so it never exceeds NUM_COL-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COL; i++) begin
                r_row_buf[i] <= '0;
            end
            r_col <= '0;
        end else if (i_capture) begin
            for (int i = 0; i < NUM_COL; i++) begin
                r_row_buf[i] <= i_row_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_col <= '0;
        end else if (w_handshake && (r_col != LAST_COL)) begin
            r_col <= r_col + COL_W'(1);
        end
    end

endmodule

// File: rtl/cpu_rd_gen.sv
// ---------------------------------------------------------------------------
// cpu_rd_gen
// CPU readback engine for the LDPC column memories. On start it walks the
// addresses 0..DEPTH-1. At each address it reads all column banks in
// parallel, captures the row, and streams it to the CPU column by column.
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : begin a frame (honoured only when idle)
//   busy / done  : frame in progress / one-cycle end-of-frame pulse
//   mem_rd_en    : registered read enable shared by all banks
//   mem_rd_addr  : registered read address shared by all banks
//   mem_rd_data  : concatenated bank read data, one cycle after mem_rd_en
//   cpu_valid / cpu_ready : stream handshake
//   cpu_data / cpu_col / cpu_addr : symbol and its position
//   cpu_last     : final beat of the frame
// ---------------------------------------------------------------------------
module cpu_rd_gen
    import ldpc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = ldpc_pkg::DATA_WIDTH,
    parameter int NUM_COL    = ldpc_pkg::NUM_COL,
    parameter int DEPTH      = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic [NUM_COL*DATA_WIDTH-1:0] mem_rd_data,
    output logic                          cpu_valid,
    input  logic                          cpu_ready,
    output logic [DATA_WIDTH-1:0]         cpu_data,
    output logic [$clog2(NUM_COL)-1:0]    cpu_col,
    output logic [ADDR_WIDTH-1:0]         cpu_addr,
    output logic                          cpu_last
);

    localparam int                    COL_W     = $clog2(NUM_COL);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(NUM_COL - 1);

    rd_state_t             r_state;
    rd_state_t             w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
    logic [COL_W-1:0]      w_col;
    logic                  w_row_end;

    rd_row_serializer #(
        .NUM_COL    (NUM_COL),
        .DATA_WIDTH (DATA_WIDTH),
        .COL_W      (COL_W)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_capture  (r_state == ST_CAP),
        .i_send     (r_state == ST_SEND),
        .i_ready    (cpu_ready),
        .i_row_data (mem_rd_data),
        .o_valid    (cpu_valid),
        .o_data     (cpu_data),
        .o_col      (w_col),
        .o_row_end  (w_row_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
        end
    end

    // Next state and address. The address only advances on the final beat
    // of a row that is not the last row, so it cannot wrap inside a frame.
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RD;
                    w_next_addr  = '0;
                end
            end
            ST_RD:   w_next_state = ST_CAP;
            ST_CAP:  w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_row_end) begin
                    if (r_addr == LAST_ADDR) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RD;
                        w_next_addr  = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The read strobe is registered from the next state, so it is high
    // exactly during RD. The address register keeps the last issued value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
        end else begin
            r_mem_rd_en <= (w_next_state == ST_RD);
            if (w_next_state == ST_RD) begin
                r_mem_rd_addr <= w_next_addr;
            end
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign cpu_col     = w_col;
    assign cpu_addr    = r_addr;
    assign cpu_last    = (r_state == ST_SEND) && (w_col == LAST_COL) && (r_addr == LAST_ADDR);

endmodule
